// File: rtl/mw_pkg.sv
// rtl/mw_pkg.sv - state encoding and default timing constants shared by the microwave controller
package mw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } mw_state_e;

    localparam int unsigned TICK_DIV_DEFAULT    = 50_000_000;
    localparam int unsigned BEEP_CYCLES_DEFAULT = 100_000_000;

endpackage

// File: rtl/mw_tick_gen.sv
// rtl/mw_tick_gen.sv - 1 Hz countdown prescaler; holds its count whenever run is low
module mw_tick_gen
    import mw_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic clear,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Holding count while !run is what lets a paused cook resume mid-second.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (restart) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (run) begin
            if (count == CNT_LAST) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/microwave_controller.sv
// rtl/microwave_controller.sv - countdown/magnetron/beep control FSM; MW_BEEP_EN builds the timed end-of-cook beep
module microwave_controller
    import mw_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int unsigned BEEP_CYCLES = BEEP_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic stop,
    input  logic door_closed,
    input  logic key_valid,
    input  logic timer_zero,
    output logic timer_loadn,
    output logic timer_clear,
    output logic timer_enable,
    output logic mag_on,
    output logic done_beep
);

    if (TICK_DIV < 2 || BEEP_CYCLES < 1) begin : g_param_check
        $error("microwave_controller: TICK_DIV must be >= 2 and BEEP_CYCLES >= 1");
    end

    mw_state_e state;
    mw_state_e state_nxt;
    logic      beep_over;

`ifdef MW_BEEP_EN
    localparam int unsigned       BEEP_W    = $clog2(BEEP_CYCLES + 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);

    logic [BEEP_W-1:0] beep_cnt;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            beep_cnt  <= '0;
            done_beep <= 1'b0;
        end else begin
            beep_cnt  <= (state == DONE) ? beep_cnt + 1'b1 : '0;
            done_beep <= (state_nxt == DONE);
        end
    end

    assign beep_over = (beep_cnt == BEEP_LAST);
`else
    assign beep_over = 1'b1;
    assign done_beep = 1'b0;
`endif

    // timer_zero outranks stop in COOK; stop outranks start everywhere else.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!stop && start && door_closed && !timer_zero) state_nxt = COOK;
            COOK: begin
                if (timer_zero)                state_nxt = DONE;
                else if (!door_closed || stop) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (stop)                      state_nxt = IDLE;
                else if (start && door_closed) state_nxt = COOK;
            end
            DONE:    if (stop || !door_closed || beep_over) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            timer_loadn <= 1'b1;
            timer_clear <= 1'b0;
            mag_on      <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer_loadn <= !(state == IDLE && key_valid);
            timer_clear <= stop && (state == IDLE || state == PAUSE);
            mag_on      <= (state_nxt == COOK);
        end
    end

    mw_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock   (clock),
        .clear   (clear),
        .run     (state == COOK),
        .restart (state == IDLE),
        .tick    (timer_enable)
    );

endmodule

// File: tb/tb_microwave_controller.sv
// tb/tb_microwave_controller.sv - scenario and randomized checks of microwave_controller against a cook-time model
module tb_microwave_controller;

    localparam int TD = 4;
    localparam int BC = 3;
`ifdef MW_BEEP_EN
    localparam int DONE_LEN = BC;
    localparam bit BEEP_ON  = 1'b1;
`else
    localparam int DONE_LEN = 1;
    localparam bit BEEP_ON  = 1'b0;
`endif

    logic clock = 1'b0;
    logic clear = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic door_closed = 1'b1;
    logic key_valid = 1'b0;
    logic timer_zero = 1'b1;
    logic timer_loadn, timer_clear, timer_enable, mag_on, done_beep;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef enum {M_IDLE, M_COOK, M_PAUSE, M_DONE} mode_e;
    mode_e mode = M_IDLE;
    int cook_cycles = 0;
    int done_cycles = 0;
    int tmr_val = 0;
    int load_val = 0;
    logic [4:0] exp_vec = 5'b10000;
    wire  [4:0] obs_vec = {timer_loadn, timer_clear, timer_enable, mag_on, done_beep};

    microwave_controller #(
        .TICK_DIV    (TD),
        .BEEP_CYCLES (BC)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .stop         (stop),
        .door_closed  (door_closed),
        .key_valid    (key_valid),
        .timer_zero   (timer_zero),
        .timer_loadn  (timer_loadn),
        .timer_clear  (timer_clear),
        .timer_enable (timer_enable),
        .mag_on       (mag_on),
        .done_beep    (done_beep)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        mode        = M_IDLE;
        cook_cycles = 0;
        done_cycles = 0;
        exp_vec     = 5'b10000;
    endtask

    // Ticks fall after every TD-th cook cycle since the last idle; the timer is a simple down-counter.
    task automatic model_step();
        mode_e nxt      = mode;
        logic  n_loadn  = 1'b1;
        logic  n_clear  = 1'b0;
        logic  n_enable = 1'b0;
        if (!exp_vec[4])                   tmr_val = load_val;
        else if (exp_vec[3])               tmr_val = 0;
        else if (exp_vec[2] && tmr_val > 0) tmr_val = tmr_val - 1;
        if (mode != M_DONE) done_cycles = 0;
        case (mode)
            M_IDLE: begin
                cook_cycles = 0;
                if (key_valid) n_loadn = 1'b0;
                if (stop) n_clear = 1'b1;
                else if (start && door_closed && !timer_zero) nxt = M_COOK;
            end
            M_COOK: begin
                cook_cycles = cook_cycles + 1;
                if (cook_cycles % TD == 0) n_enable = 1'b1;
                if (timer_zero) nxt = M_DONE;
                else if (!door_closed || stop) nxt = M_PAUSE;
            end
            M_PAUSE: begin
                if (stop) begin
                    n_clear = 1'b1;
                    nxt = M_IDLE;
                end else if (start && door_closed) nxt = M_COOK;
            end
            M_DONE: begin
                done_cycles = done_cycles + 1;
                if (stop || !door_closed || done_cycles >= DONE_LEN) nxt = M_IDLE;
            end
        endcase
        mode    = nxt;
        exp_vec = {n_loadn, n_clear, n_enable, (nxt == M_COOK), (BEEP_ON && nxt == M_DONE)};
        cyc     = cyc + 1;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        timer_zero = (tmr_val == 0);
    endtask

    task automatic load_timer(input int val);
        load_val  = val;
        key_valid = 1'b1;
        cycle();
        checks++;
        if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL load_key cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
        end
        key_valid = 1'b0;
        repeat (2) begin
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL load_settle cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_vec !== 5'b10000) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", obs_vec, 5'b10000);
        end
        @(negedge clock);
        clear = 1'b0;
        repeat (3) begin
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_key_load();
        int low = 0;
        repeat ($urandom_range(1, 3)) begin
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL key_pre cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
        load_val  = $urandom_range(1, 9);
        key_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            key_valid = 1'b0;
            if (!timer_loadn) low++;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL key_load cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (low !== 1) begin
            errors++;
            $display("FAIL key_load_width: got %0d low cycles want 1", low);
        end
    endtask

    task automatic test_cook_to_done();
        int ticks = 0;
        int beeps = 0;
        int mags  = 0;
        bit seen_done = 1'b0;
        bit finished  = 1'b0;
        door_closed = 1'b1;
        load_timer(3);
        start = 1'b1;
        for (int i = 0; i < 60 && !finished; i++) begin
            cycle();
            start = 1'b0;
            ticks += int'(timer_enable);
            beeps += int'(done_beep);
            mags  += int'(mag_on);
            if (mode == M_DONE) seen_done = 1'b1;
            if (seen_done && mode == M_IDLE) finished = 1'b1;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL cook cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL cook_timeout: got no return to idle want idle within 60 cycles");
        end
        checks++;
        if (ticks !== 3) begin
            errors++;
            $display("FAIL cook_ticks: got %0d want 3", ticks);
        end
        checks++;
        if (mags !== 3 * TD + 2) begin
            errors++;
            $display("FAIL cook_mag_cycles: got %0d want %0d", mags, 3 * TD + 2);
        end
        checks++;
        if (beeps !== (BEEP_ON ? BC : 0)) begin
            errors++;
            $display("FAIL beep_cycles: got %0d want %0d", beeps, BEEP_ON ? BC : 0);
        end
    endtask

    task automatic test_pause_resume();
        int n = 0;
        bit got = 1'b0;
        load_timer(5);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        door_closed = 1'b0;
        cycle();
        checks++;
        if (mag_on !== 1'b0 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL door_open cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
        end
        repeat (2) cycle();
        door_closed = 1'b1;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if (mag_on !== 1'b1 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL resume cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            n++;
            if (timer_enable) got = 1'b1;
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL resume_run cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
        checks++;
        if (!got || n !== 2) begin
            errors++;
            $display("FAIL resume_tick_delay: got %0d want 2", n);
        end
        door_closed = 1'b0;
        cycle();
        door_closed = 1'b1;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++;
        if (timer_clear !== 1'b1 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL pause_stop cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
        end
        cycle();
        checks++;
        if (timer_clear !== 1'b0 || mag_on !== 1'b0 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL pause_stop_after cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
        end
    endtask

    task automatic test_start_blocked();
        int mags = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        mags += int'(mag_on);
        repeat (3) begin
            cycle();
            mags += int'(mag_on);
        end
        load_timer(2);
        door_closed = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        mags += int'(mag_on);
        cycle();
        mags += int'(mag_on);
        door_closed = 1'b1;
        checks++;
        if (mags !== 0 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL start_blocked: got %0d mag cycles, outputs %b want 0, %b", mags, obs_vec, exp_vec);
        end
    endtask

    task automatic test_start_stop_together();
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (timer_clear !== 1'b1 || mag_on !== 1'b0 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL start_stop cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
        end
        repeat (3) begin
            cycle();
            checks++;
            if (mag_on !== 1'b0 || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL start_stop_after cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_cook();
        load_timer(3);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        checks++;
        if (mag_on !== 1'b1 || obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL pre_reset_cook cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
        end
        #2;
        clear = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_vec !== 5'b10000) begin
            errors++;
            $display("FAIL reset_mid_cook: got %b want %b", obs_vec, 5'b10000);
        end
        @(negedge clock);
        clear = 1'b0;
        repeat (3) begin
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 9) == 0) door_closed = !door_closed;
            key_valid = ($urandom_range(0, 7) == 0);
            if (key_valid) load_val = $urandom_range(0, 3);
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", cyc, obs_vec, exp_vec);
            end
        end
        start = 1'b0;
        stop = 1'b0;
        key_valid = 1'b0;
        door_closed = 1'b1;
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_cook_to_done();
        test_pause_resume();
        test_start_blocked();
        test_start_stop_together();
        test_reset_mid_cook();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
